// File: rtl/rob_recovery_ctrl_if.sv
// Purpose: bundle of ROB/map-table/dispatch signals around the mispredict recovery controller.
// Latency: wires only; all timing is owned by rob_recovery_ctrl.
// Backpressure: none on this bundle; the controller stalls dispatch/retire via stall_* while active.
//
// Ports (master = recovery controller, slave = surrounding pipeline/testbench):
//   mispredict/mispredict_idx   resolved branch mispredict and its ROB index
//   rob_head/retire_cnt         oldest ROB entry and entries retiring this cycle (0..2)
//   rd_ptr_0/1, ent_0/1_*       two-lane combinational ROB read used by the walk
//   rob_state, walk_0/1_*       recovery phase and rename replay lanes to the map table
//   stall_*, tail_load/new_tail dispatch/retire stall and ROB tail reload
//   recover_cnt/recover_cycles  optional performance counters
interface rob_recovery_ctrl_if #(
    parameter int ROB_PTR_W = 5,
    parameter int ARF_WIDTH = 5,
    parameter int PRF_WIDTH = 6
);
    logic                 mispredict;
    logic [ROB_PTR_W-1:0] mispredict_idx;
    logic [ROB_PTR_W-1:0] rob_head;
    logic [1:0]           retire_cnt;

    logic [ROB_PTR_W-1:0] rd_ptr_0;
    logic [ROB_PTR_W-1:0] rd_ptr_1;
    logic                 ent_0_rd_valid;
    logic                 ent_1_rd_valid;
    logic [ARF_WIDTH-1:0] ent_0_rd_id;
    logic [ARF_WIDTH-1:0] ent_1_rd_id;
    logic [PRF_WIDTH-1:0] ent_0_T;
    logic [PRF_WIDTH-1:0] ent_1_T;

    logic [1:0]           rob_state;
    logic                 walk_0_valid;
    logic                 walk_1_valid;
    logic [ARF_WIDTH-1:0] walk_0_rd_id;
    logic [ARF_WIDTH-1:0] walk_1_rd_id;
    logic [PRF_WIDTH-1:0] walk_0_rd_prf;
    logic [PRF_WIDTH-1:0] walk_1_rd_prf;

    logic                 stall_dispatch;
    logic                 stall_retire;
    logic                 tail_load;
    logic [ROB_PTR_W-1:0] new_tail;

    logic [15:0]          recover_cnt;
    logic [15:0]          recover_cycles;

    modport master (
        input  mispredict, mispredict_idx, rob_head, retire_cnt,
        input  ent_0_rd_valid, ent_1_rd_valid, ent_0_rd_id, ent_1_rd_id, ent_0_T, ent_1_T,
        output rd_ptr_0, rd_ptr_1, rob_state,
        output walk_0_valid, walk_1_valid, walk_0_rd_id, walk_1_rd_id, walk_0_rd_prf, walk_1_rd_prf,
        output stall_dispatch, stall_retire, tail_load, new_tail,
        output recover_cnt, recover_cycles
    );

    modport slave (
        output mispredict, mispredict_idx, rob_head, retire_cnt,
        output ent_0_rd_valid, ent_1_rd_valid, ent_0_rd_id, ent_1_rd_id, ent_0_T, ent_1_T,
        input  rd_ptr_0, rd_ptr_1, rob_state,
        input  walk_0_valid, walk_1_valid, walk_0_rd_id, walk_1_rd_id, walk_0_rd_prf, walk_1_rd_prf,
        input  stall_dispatch, stall_retire, tail_load, new_tail,
        input  recover_cnt, recover_cycles
    );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// Purpose: branch-mispredict recovery of the rename map: 1 rollback cycle (RAT <- RRAT), then a
//          two-lane replay walk of ROB entries from the oldest uncommitted one up to the branch.
// Latency: mispredict at t -> rollback at t+1, walk from t+2 at 2 entries/cycle, tail_load the cycle after the last walk.
// Backpressure: none accepted; stall_dispatch/stall_retire are held while rob_state != idle.
//
// Ports: clk, reset (async, active-high) and the rob_recovery_ctrl_if master modport:
//   in : mispredict, mispredict_idx, rob_head, retire_cnt, ent_0/1_{rd_valid,rd_id,T}
//   out: rd_ptr_0/1, rob_state, walk_0/1_{valid,rd_id,rd_prf}, stall_dispatch, stall_retire,
//        tail_load, new_tail, recover_cnt, recover_cycles
// Optional feature macro: RECOVERY_PERF_CNT_EN (recovery/cycle counters; tied to 0 when undefined).
module rob_recovery_ctrl #(
    parameter int ROB_DEPTH = 32,
    parameter int ROB_PTR_W = 5,
    parameter int ARF_WIDTH = 5,
    parameter int PRF_WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    rob_recovery_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ROLLBACK = 2'b01,
        ST_WALK     = 2'b10
    } state_t;

    localparam logic [ROB_PTR_W:0] REM_TWO = (ROB_PTR_W+1)'(2);

    state_t               state_q,     state_d;
    logic [ROB_PTR_W-1:0] walk_ptr_q,  walk_ptr_d;
    logic [ROB_PTR_W-1:0] start_q,     start_d;
    logic [ROB_PTR_W-1:0] end_idx_q,   end_idx_d;
    logic [ROB_PTR_W:0]   remaining_q, remaining_d;
    logic                 tail_load_q, tail_load_d;

    logic [ROB_PTR_W-1:0] fresh_start;
    logic [ROB_PTR_W-1:0] fresh_dist;
    logic [ROB_PTR_W-1:0] new_dist;
    logic [ROB_PTR_W-1:0] end_dist;
    logic                 restart_req;
    logic                 fresh_req;
    logic [ROB_PTR_W:0]   consumed;
    logic                 last_walk;

    // Entries retiring on the same edge as the mispredict are already in the RRAT,
    // so the walk begins just past them.
    assign fresh_start = bus.rob_head + ROB_PTR_W'(bus.retire_cnt);
    assign fresh_dist  = bus.mispredict_idx - fresh_start;

    // Ages are compared as distances from the fixed walk start; a smaller distance
    // means an older branch, which supersedes the recovery in progress.
    assign new_dist    = bus.mispredict_idx - start_q;
    assign end_dist    = end_idx_q - start_q;
    assign restart_req = (state_q != ST_IDLE) && bus.mispredict && (new_dist < end_dist);
    assign fresh_req   = (state_q == ST_IDLE) && bus.mispredict;

    assign consumed    = (remaining_q >= REM_TWO) ? REM_TWO : remaining_q;
    assign last_walk   = (remaining_q == consumed);

    always_comb begin
        state_d     = state_q;
        walk_ptr_d  = walk_ptr_q;
        start_d     = start_q;
        end_idx_d   = end_idx_q;
        remaining_d = remaining_q;
        tail_load_d = 1'b0;

        if (fresh_req) begin
            start_d     = fresh_start;
            walk_ptr_d  = fresh_start;
            end_idx_d   = bus.mispredict_idx;
            remaining_d = {1'b0, fresh_dist} + (ROB_PTR_W+1)'(1);
            state_d     = ST_ROLLBACK;
        end else if (restart_req) begin
            // Restart wins over walk completion: the younger walk must not finish.
            // start is kept because retire stays stalled for the whole recovery.
            walk_ptr_d  = start_q;
            end_idx_d   = bus.mispredict_idx;
            remaining_d = {1'b0, new_dist} + (ROB_PTR_W+1)'(1);
            state_d     = ST_ROLLBACK;
        end else begin
            case (state_q)
                ST_ROLLBACK: state_d = ST_WALK;
                ST_WALK: begin
                    walk_ptr_d  = walk_ptr_q + consumed[ROB_PTR_W-1:0];
                    remaining_d = remaining_q - consumed;
                    if (last_walk) begin
                        state_d     = ST_IDLE;
                        tail_load_d = 1'b1;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            walk_ptr_q  <= '0;
            start_q     <= '0;
            end_idx_q   <= '0;
            remaining_q <= '0;
            tail_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            walk_ptr_q  <= walk_ptr_d;
            start_q     <= start_d;
            end_idx_q   <= end_idx_d;
            remaining_q <= remaining_d;
            tail_load_q <= tail_load_d;
        end
    end

    // Replay lanes: ROB read is combinational, fields pass straight through.
    // Lane 1 is only meaningful while at least two entries remain.
    assign bus.rd_ptr_0       = walk_ptr_q;
    assign bus.rd_ptr_1       = walk_ptr_q + ROB_PTR_W'(1);
    assign bus.walk_0_valid   = (state_q == ST_WALK) && bus.ent_0_rd_valid;
    assign bus.walk_1_valid   = (state_q == ST_WALK) && bus.ent_1_rd_valid && (remaining_q >= REM_TWO);
    assign bus.walk_0_rd_id   = bus.ent_0_rd_id;
    assign bus.walk_1_rd_id   = bus.ent_1_rd_id;
    assign bus.walk_0_rd_prf  = bus.ent_0_T;
    assign bus.walk_1_rd_prf  = bus.ent_1_T;

    assign bus.rob_state      = state_q;
    assign bus.stall_dispatch = (state_q != ST_IDLE);
    assign bus.stall_retire   = (state_q != ST_IDLE);
    assign bus.tail_load      = tail_load_q;
    // end_idx is still the completed recovery's branch during the tail_load cycle.
    assign bus.new_tail       = end_idx_q + ROB_PTR_W'(1);

`ifdef RECOVERY_PERF_CNT_EN
    logic [15:0] recover_cnt_q,    recover_cnt_d;
    logic [15:0] recover_cycles_q, recover_cycles_d;

    always_comb begin
        recover_cnt_d    = recover_cnt_q;
        recover_cycles_d = recover_cycles_q;
        if ((fresh_req || restart_req) && (recover_cnt_q != 16'hFFFF)) begin
            recover_cnt_d = recover_cnt_q + 16'd1;
        end
        if ((state_q != ST_IDLE) && (recover_cycles_q != 16'hFFFF)) begin
            recover_cycles_d = recover_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recover_cnt_q    <= '0;
            recover_cycles_q <= '0;
        end else begin
            recover_cnt_q    <= recover_cnt_d;
            recover_cycles_q <= recover_cycles_d;
        end
    end

    assign bus.recover_cnt    = recover_cnt_q;
    assign bus.recover_cycles = recover_cycles_q;
`else
    assign bus.recover_cnt    = 16'd0;
    assign bus.recover_cycles = 16'd0;
`endif

`ifndef SYNTHESIS
    localparam logic [ROB_PTR_W:0] REM_MAX = (ROB_PTR_W+1)'(ROB_DEPTH);
    logic [ROB_PTR_W-1:0] retire_dist;
    assign retire_dist = bus.mispredict_idx - bus.rob_head;

    // A branch cannot both retire and mispredict in the same cycle.
    a_mispredict_not_retiring: assert property (@(posedge clk) disable iff (reset)
        fresh_req |-> (retire_dist >= ROB_PTR_W'(bus.retire_cnt)));

    a_remaining_in_range: assert property (@(posedge clk) disable iff (reset)
        remaining_q <= REM_MAX);
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Purpose: directed self-checking bench for rob_recovery_ctrl with a combinational ROB model.
// Latency: expectations are per-cycle tables sampled on the falling clock edge.
// Backpressure: not applicable; stimulus is driven on the falling edge.
module tb_rob_recovery_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [31:0] store_mask;

    rob_recovery_ctrl_if #(.ROB_PTR_W(5), .ARF_WIDTH(5), .PRF_WIDTH(6)) bus ();

    rob_recovery_ctrl #(
        .ROB_DEPTH(32), .ROB_PTR_W(5), .ARF_WIDTH(5), .PRF_WIDTH(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROB model: entry i writes arch reg i^0x15 into PRF {1,i}; masked entries are stores.
    assign bus.ent_0_rd_valid = ~store_mask[bus.rd_ptr_0];
    assign bus.ent_1_rd_valid = ~store_mask[bus.rd_ptr_1];
    assign bus.ent_0_rd_id    = bus.rd_ptr_0 ^ 5'h15;
    assign bus.ent_1_rd_id    = bus.rd_ptr_1 ^ 5'h15;
    assign bus.ent_0_T        = {1'b1, bus.rd_ptr_0};
    assign bus.ent_1_T        = {1'b1, bus.rd_ptr_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, v0, v1, rd_ptr_0, rd_ptr_1, stall_d, stall_r, tail_load, new_tail-if-tail_load}
    function automatic logic [21:0] ex(logic [1:0] st, logic v0, logic v1, logic [4:0] p,
                                       logic tl, logic [4:0] nt);
        logic [4:0] p1;
        p1 = p + 5'd1;
        return {st, v0, v1, p, p1, (st != 2'b00), (st != 2'b00), tl, nt};
    endfunction

    function automatic logic [21:0] obs();
        return {bus.rob_state, bus.walk_0_valid, bus.walk_1_valid, bus.rd_ptr_0, bus.rd_ptr_1,
                bus.stall_dispatch, bus.stall_retire, bus.tail_load,
                bus.tail_load ? bus.new_tail : 5'd0};
    endfunction

    task automatic launch(input logic [4:0] head, input logic [1:0] rc, input logic [4:0] idx);
        bus.rob_head       = head;
        bus.retire_cnt     = rc;
        bus.mispredict_idx = idx;
        bus.mispredict     = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        if (obs() !== ex(2'b00, 0, 0, 5'd0, 0, 5'd0)) begin
            $display("FAIL reset_state: got %h want %h", obs(), ex(2'b00, 0, 0, 5'd0, 0, 5'd0));
            n_bad++;
        end
        n_cmp++;
        if (bus.recover_cnt !== 16'd0 || bus.recover_cycles !== 16'd0) begin
            $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.recover_cnt, bus.recover_cycles);
            n_bad++;
        end
        n_cmp++;
        reset = 1'b0;
        @(negedge clk);
        if (obs() !== ex(2'b00, 0, 0, 5'd0, 0, 5'd0)) begin
            $display("FAIL post_reset_idle: got %h want %h", obs(), ex(2'b00, 0, 0, 5'd0, 0, 5'd0));
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_basic_walk();
        logic [21:0] e [6];
        e = '{ex(2'b01, 0, 0, 5'd3, 0, 5'd0), ex(2'b10, 1, 1, 5'd3, 0, 5'd0),
              ex(2'b10, 1, 1, 5'd5, 0, 5'd0), ex(2'b10, 1, 0, 5'd7, 0, 5'd0),
              ex(2'b00, 0, 0, 5'd8, 1, 5'd8), ex(2'b00, 0, 0, 5'd8, 0, 5'd0)};
        launch(5'd3, 2'd0, 5'd7);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            if (obs() !== e[i]) begin
                $display("FAIL basic_walk cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
            if (i == 1) begin
                if (bus.walk_0_rd_id !== 5'd22 || bus.walk_0_rd_prf !== 6'd35 ||
                    bus.walk_1_rd_id !== 5'd17 || bus.walk_1_rd_prf !== 6'd36) begin
                    $display("FAIL basic_passthru: got %0d/%0d %0d/%0d want 22/35 17/36",
                             bus.walk_0_rd_id, bus.walk_0_rd_prf, bus.walk_1_rd_id, bus.walk_1_rd_prf);
                    n_bad++;
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [21:0] e [4];
        e = '{ex(2'b01, 0, 0, 5'd30, 0, 5'd0), ex(2'b10, 1, 1, 5'd30, 0, 5'd0),
              ex(2'b10, 1, 1, 5'd0, 0, 5'd0),  ex(2'b00, 0, 0, 5'd2, 1, 5'd2)};
        @(negedge clk);
        launch(5'd30, 2'd0, 5'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            if (obs() !== e[i]) begin
                $display("FAIL wrap cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_retire_same_edge();
        logic [21:0] e [3];
        e = '{ex(2'b01, 0, 0, 5'd7, 0, 5'd0), ex(2'b10, 1, 0, 5'd7, 0, 5'd0),
              ex(2'b00, 0, 0, 5'd8, 1, 5'd8)};
        @(negedge clk);
        launch(5'd5, 2'd2, 5'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            bus.retire_cnt = 2'd0;
            if (obs() !== e[i]) begin
                $display("FAIL retire_edge cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_restart();
        logic [21:0] e [9];
        e = '{ex(2'b01, 0, 0, 5'd0, 0, 5'd0), ex(2'b10, 1, 1, 5'd0, 0, 5'd0),
              ex(2'b10, 1, 1, 5'd2, 0, 5'd0), ex(2'b01, 0, 0, 5'd0, 0, 5'd0),
              ex(2'b10, 1, 1, 5'd0, 0, 5'd0), ex(2'b10, 1, 1, 5'd2, 0, 5'd0),
              ex(2'b10, 1, 0, 5'd4, 0, 5'd0), ex(2'b00, 0, 0, 5'd5, 1, 5'd5),
              ex(2'b00, 0, 0, 5'd5, 0, 5'd0)};
        @(negedge clk);
        launch(5'd0, 2'd0, 5'd10);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            if (obs() !== e[i]) begin
                $display("FAIL restart cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
            if (i == 2) begin          // older branch during the 2nd walk cycle
                bus.mispredict_idx = 5'd4;
                bus.mispredict     = 1'b1;
            end else if (i == 5) begin // younger branch: must be ignored
                bus.mispredict_idx = 5'd9;
                bus.mispredict     = 1'b1;
            end
        end
    endtask

    task automatic test_stores();
        logic [21:0] e [4];
        e = '{ex(2'b01, 0, 0, 5'd8, 0, 5'd0),  ex(2'b10, 1, 0, 5'd8, 0, 5'd0),
              ex(2'b10, 0, 1, 5'd10, 0, 5'd0), ex(2'b00, 0, 0, 5'd12, 1, 5'd12)};
        @(negedge clk);
        store_mask = 32'h0000_0600;    // entries 9 and 10 are stores
        launch(5'd8, 2'd0, 5'd11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            if (obs() !== e[i]) begin
                $display("FAIL stores cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
        end
        store_mask = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [21:0] e [6];
        logic [15:0] want_cnt;
        logic [15:0] want_cyc;
        e = '{ex(2'b01, 0, 0, 5'd12, 0, 5'd0), ex(2'b10, 1, 1, 5'd12, 0, 5'd0),
              ex(2'b00, 0, 0, 5'd14, 1, 5'd14), ex(2'b01, 0, 0, 5'd14, 0, 5'd0),
              ex(2'b10, 1, 0, 5'd14, 0, 5'd0), ex(2'b00, 0, 0, 5'd15, 1, 5'd15)};
        @(negedge clk);
        launch(5'd12, 2'd0, 5'd13);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.mispredict = 1'b0;
            if (obs() !== e[i]) begin
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs(), e[i]);
                n_bad++;
            end
            n_cmp++;
            if (i == 2) launch(5'd14, 2'd0, 5'd14);   // fresh recovery in the tail_load cycle
        end
`ifdef RECOVERY_PERF_CNT_EN
        want_cnt = 16'd8;
        want_cyc = 16'd23;
`else
        want_cnt = 16'd0;
        want_cyc = 16'd0;
`endif
        if (bus.recover_cnt !== want_cnt || bus.recover_cycles !== want_cyc) begin
            $display("FAIL perf_counters: got %0d/%0d want %0d/%0d",
                     bus.recover_cnt, bus.recover_cycles, want_cnt, want_cyc);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_walk();
        @(negedge clk);
        launch(5'd0, 2'd0, 5'd20);
        @(negedge clk);
        bus.mispredict = 1'b0;
        @(negedge clk);
        if (obs() !== ex(2'b10, 1, 1, 5'd0, 0, 5'd0)) begin
            $display("FAIL midwalk_pre: got %h want %h", obs(), ex(2'b10, 1, 1, 5'd0, 0, 5'd0));
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        if (obs() !== ex(2'b00, 0, 0, 5'd0, 0, 5'd0)) begin
            $display("FAIL midwalk_reset: got %h want %h", obs(), ex(2'b00, 0, 0, 5'd0, 0, 5'd0));
            n_bad++;
        end
        n_cmp++;
        if (bus.recover_cnt !== 16'd0 || bus.recover_cycles !== 16'd0) begin
            $display("FAIL midwalk_counters: got %0d/%0d want 0/0", bus.recover_cnt, bus.recover_cycles);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (obs() !== ex(2'b00, 0, 0, 5'd0, 0, 5'd0)) begin
                $display("FAIL midwalk_after cyc%0d: got %h want %h", i, obs(), ex(2'b00, 0, 0, 5'd0, 0, 5'd0));
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp              = 0;
        n_bad              = 0;
        store_mask         = 32'd0;
        reset              = 1'b1;
        bus.mispredict     = 1'b0;
        bus.mispredict_idx = 5'd0;
        bus.rob_head       = 5'd0;
        bus.retire_cnt     = 2'd0;
        test_reset();
        test_basic_walk();
        test_wrap();
        test_retire_same_edge();
        test_restart();
        test_stores();
        test_back_to_back();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_recovery_ctrl.md
Name: rob_recovery_ctrl

Overview:
- Sequences branch-misprediction recovery of the rename map table.
- On a mispredict, drives rob_state through rollback (RAT <- RRAT), then walks ROB entries from oldest uncommitted up to and including the mispredicting branch. Replays their renames two per cycle on the map table's walk_0/walk_1 ports.
- Stalls dispatch and retire while active, and reloads the ROB tail when done.

Parameters:
- ROB_DEPTH, 32, ROB entries; power of two.
- ROB_PTR_W, 5, log2(ROB_DEPTH).
- ARF_WIDTH, 5, architectural register id width.
- PRF_WIDTH, 6, physical register id width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mispredict  in  1  branch misprediction resolved this cycle.
- mispredict_idx  in  ROB_PTR_W  ROB index of mispredicting branch.
- rob_head  in  ROB_PTR_W  current ROB head (oldest entry).
- retire_cnt  in  2  entries retiring this cycle (0..2).
- rd_ptr_0  out  ROB_PTR_W  ROB read index, walk lane 0.
- rd_ptr_1  out  ROB_PTR_W  ROB read index, walk lane 1 (rd_ptr_0+1 mod ROB_DEPTH).
- ent_0_rd_valid, ent_1_rd_valid  in  1  entry writes a destination (combinational ROB read).
- ent_0_rd_id, ent_1_rd_id  in  ARF_WIDTH  entry destination arch reg.
- ent_0_T, ent_1_T  in  PRF_WIDTH  entry allocated PRF.
- rob_state  out  2  00 idle, 01 rollback, 10 walk.
- walk_0_valid, walk_1_valid  out  1  replay lane valid.
- walk_0_rd_id, walk_1_rd_id  out  ARF_WIDTH.
- walk_0_rd_prf, walk_1_rd_prf  out  PRF_WIDTH.
- stall_dispatch  out  1  high whenever rob_state != idle.
- stall_retire  out  1  high whenever rob_state != idle.
- tail_load  out  1  one-cycle pulse on walk completion.
- new_tail  out  ROB_PTR_W  mispredict_idx+1 mod ROB_DEPTH; valid with tail_load.
- recover_cnt  out  16  recoveries started (optional feature).
- recover_cycles  out  16  cycles with rob_state != idle (optional feature).

Behaviour:
- Reset (async): state IDLE, rob_state=00; walk valids, tail_load, stalls = 0; internal pointers = 0; counters = 0.
- Registers: walk_ptr (start), end_idx, remaining (ROB_PTR_W+1 bits).
- IDLE + mispredict at cycle t:
  - Capture start = rob_head + retire_cnt mod ROB_DEPTH, so same-edge retires are already in RRAT.
  - Capture end_idx = mispredict_idx.
  - remaining = ((end_idx - start) mod ROB_DEPTH) + 1, range 1..ROB_DEPTH.
  - Go to ROLLBACK at t+1.
- ROLLBACK: exactly 1 cycle, rob_state=01; walk valids 0; then WALK.
- WALK: rob_state=10; rd_ptr_0=walk_ptr, rd_ptr_1=walk_ptr+1.
  - walk_0_valid = ent_0_rd_valid.
  - walk_1_valid = ent_1_rd_valid && remaining>=2.
  - walk_x_rd_id / walk_x_rd_prf pass ent_x fields through combinationally.
  - Per cycle: consumed = min(2, remaining); walk_ptr += consumed (wraps mod ROB_DEPTH); remaining -= consumed.
  - When remaining==consumed, this is the last walk cycle: the next cycle is IDLE with tail_load=1.
- Walk valids are low outside WALK. rd_ptr holds walk_ptr in all states.
- Same-rd pairs are resolved by the map table (lane 1 wins); no extra handling here.
- Mispredict while in ROLLBACK or WALK:
  - If (mispredict_idx - start) mod ROB_DEPTH < (end_idx - start) mod ROB_DEPTH (older branch): restart.
  - Restart means end_idx = mispredict_idx, walk_ptr = start (start unchanged, retire stalled), recompute remaining, go to ROLLBACK next cycle.
  - Otherwise ignore.
- Mispredict coincident with tail_load cycle (IDLE): treated as a fresh recovery.
- mispredict_idx among same-cycle retiring entries: illegal; simulation assertion fires.
- Reset mid-walk: immediate return to IDLE, no tail_load.
- Worst case: remaining=ROB_DEPTH gives 1 + ROB_DEPTH/2 non-idle cycles.

Optional Feature:
- Macro: RECOVERY_PERF_CNT_EN.
- Defined: recover_cnt increments on each IDLE->ROLLBACK and each restart; recover_cycles increments each non-idle cycle. Both saturate at 0xFFFF and are cleared by reset.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- head=3, retire_cnt=0, mispredict_idx=7 -> 1 rollback cycle, walk ptrs 3/4, 5/6, then 7 alone (walk_1_valid=0), tail_load with new_tail=8; stalls high for 4 cycles.
- head=30, mispredict_idx=1 -> walk 30/31, 0/1, 2 cycles; new_tail=2 (wrap).
- head=5, retire_cnt=2, mispredict_idx=7 -> start=7, remaining=1, single walk cycle on entry 7, new_tail=8.
- Walk from head=0 to idx=10; during 2nd walk cycle mispredict idx=4 -> rollback next cycle, rewalk 0..4, new_tail=5. A later mispredict idx=9 during that walk is ignored.
- Entries with rd_valid=0 (stores) inside the walk -> corresponding walk_x_valid=0, pointer still advances.
- reset asserted mid-walk -> rob_state=00, valids 0 immediately, no tail_load; with RECOVERY_PERF_CNT_EN, counters read 0.
